// File: rtl/point_double.sv
// Jacobian point doubling for a = -3 curves, using a bit-serial modular multiplier and a single-cycle add/sub unit.
// Define POINT_DOUBLE_INF_CHECK_EN to short-circuit inputs with y==0 or z==0 to the point at infinity.
module point_double #(
    parameter int LEN = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [LEN-1:0] p,
    input  logic           enable,
    input  logic [LEN-1:0] x,
    input  logic [LEN-1:0] y,
    input  logic [LEN-1:0] z,
    output logic [LEN-1:0] rx,
    output logic [LEN-1:0] ry,
    output logic [LEN-1:0] rz,
    output logic           done
);

    localparam int         CW        = $clog2(LEN + 1);
    localparam logic [4:0] LAST_STEP = 5'd23;

    typedef enum logic [2:0] {IDLE, LOAD, MUL, ADDSUB, DONE} state_t;

    state_t         r_state, w_nextState;
    logic [LEN-1:0] r_reg [8];
    logic [LEN-1:0] r_p, r_acc, r_ma, r_mb, r_rx, r_ry, r_rz;
    logic [4:0]     r_step;
    logic [CW-1:0]  r_cnt;

    logic           w_isSub, w_mulDone, w_lastStep, w_inf;
    logic [2:0]     w_dst, w_srcA, w_srcB;
    logic [LEN-1:0] w_opA, w_opB, w_asRes, w_mulNext;
    logic [LEN:0]   w_pe, w_sum, w_diff, w_dbl, w_dblRed, w_addB;

    // Register map: 0=X/X3, 1=Y/Y3, 2=Z/Z3, 3=delta, 4=gamma, 5=beta, 6=alpha, 7=scratch.
    function automatic logic isMulStep(input logic [4:0] s);
        case (s)
            5'd0, 5'd1, 5'd2, 5'd5, 5'd8, 5'd14, 5'd18, 5'd19: isMulStep = 1'b1;
            default:                                            isMulStep = 1'b0;
        endcase
    endfunction

    // Encoding is {isSub, dst, srcA, srcB}; multiplies compute srcA*srcB.
    function automatic logic [9:0] stepOp(input logic [4:0] s);
        case (s)
            5'd0:    stepOp = {1'b0, 3'd3, 3'd2, 3'd2};
            5'd1:    stepOp = {1'b0, 3'd4, 3'd1, 3'd1};
            5'd2:    stepOp = {1'b0, 3'd5, 3'd0, 3'd4};
            5'd3:    stepOp = {1'b1, 3'd6, 3'd0, 3'd3};
            5'd4:    stepOp = {1'b0, 3'd7, 3'd0, 3'd3};
            5'd5:    stepOp = {1'b0, 3'd6, 3'd6, 3'd7};
            5'd6:    stepOp = {1'b0, 3'd7, 3'd6, 3'd6};
            5'd7:    stepOp = {1'b0, 3'd6, 3'd7, 3'd6};
            5'd8:    stepOp = {1'b0, 3'd7, 3'd6, 3'd6};
            5'd9:    stepOp = {1'b0, 3'd5, 3'd5, 3'd5};
            5'd10:   stepOp = {1'b0, 3'd5, 3'd5, 3'd5};
            5'd11:   stepOp = {1'b0, 3'd0, 3'd5, 3'd5};
            5'd12:   stepOp = {1'b1, 3'd0, 3'd7, 3'd0};
            5'd13:   stepOp = {1'b0, 3'd7, 3'd1, 3'd2};
            5'd14:   stepOp = {1'b0, 3'd7, 3'd7, 3'd7};
            5'd15:   stepOp = {1'b1, 3'd7, 3'd7, 3'd4};
            5'd16:   stepOp = {1'b1, 3'd2, 3'd7, 3'd3};
            5'd17:   stepOp = {1'b1, 3'd5, 3'd5, 3'd0};
            5'd18:   stepOp = {1'b0, 3'd5, 3'd6, 3'd5};
            5'd19:   stepOp = {1'b0, 3'd4, 3'd4, 3'd4};
            5'd20:   stepOp = {1'b0, 3'd4, 3'd4, 3'd4};
            5'd21:   stepOp = {1'b0, 3'd4, 3'd4, 3'd4};
            5'd22:   stepOp = {1'b0, 3'd4, 3'd4, 3'd4};
            5'd23:   stepOp = {1'b1, 3'd1, 3'd5, 3'd4};
            default: stepOp = '0;
        endcase
    endfunction

    assign {w_isSub, w_dst, w_srcA, w_srcB} = stepOp(r_step);
    assign w_opA      = r_reg[w_srcA];
    assign w_opB      = r_reg[w_srcB];
    assign w_pe       = {1'b0, r_p};
    assign w_mulDone  = (r_cnt == CW'(LEN));
    assign w_lastStep = (r_step == LAST_STEP);

    assign w_sum   = {1'b0, w_opA} + {1'b0, w_opB};
    assign w_diff  = {1'b0, w_opA} - {1'b0, w_opB};
    assign w_asRes = w_isSub ? (w_diff[LEN] ? LEN'(w_diff + w_pe) : LEN'(w_diff))
                             : ((w_sum >= w_pe) ? LEN'(w_sum - w_pe) : LEN'(w_sum));

    // One MSB-first interleaved step: acc = 2*acc mod p, then conditionally add b mod p.
    assign w_dbl     = {r_acc, 1'b0};
    assign w_dblRed  = (w_dbl >= w_pe) ? (w_dbl - w_pe) : w_dbl;
    assign w_addB    = w_dblRed + (r_ma[LEN-1] ? {1'b0, r_mb} : '0);
    assign w_mulNext = (w_addB >= w_pe) ? LEN'(w_addB - w_pe) : LEN'(w_addB);

`ifdef POINT_DOUBLE_INF_CHECK_EN
    assign w_inf = (r_state == MUL) && (r_step == 5'd0) && (r_cnt == '0) &&
                   ((r_reg[1] == '0) || (r_reg[2] == '0));
`else
    assign w_inf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (enable) w_nextState = LOAD;
            LOAD:    w_nextState = enable ? MUL : IDLE;
            MUL: begin
                if (!enable)                  w_nextState = IDLE;
                else if (w_inf)               w_nextState = DONE;
                else if (r_cnt != '0 && w_mulDone)
                    w_nextState = w_lastStep ? DONE : (isMulStep(r_step + 5'd1) ? MUL : ADDSUB);
            end
            ADDSUB: begin
                if (!enable)         w_nextState = IDLE;
                else if (w_lastStep) w_nextState = DONE;
                else                 w_nextState = isMulStep(r_step + 5'd1) ? MUL : ADDSUB;
            end
            DONE:    if (!enable) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Results only update on successful completion, so aborts leave the previous result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_reg[i] <= '0;
            r_p    <= '0;
            r_acc  <= '0;
            r_ma   <= '0;
            r_mb   <= '0;
            r_rx   <= '0;
            r_ry   <= '0;
            r_rz   <= '0;
            r_step <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_step <= '0;
                    r_cnt  <= '0;
                end
                LOAD: if (enable) begin
                    r_reg[0] <= x;
                    r_reg[1] <= y;
                    r_reg[2] <= z;
                    r_p      <= p;
                    r_step   <= '0;
                    r_cnt    <= '0;
                end
                MUL: if (enable) begin
                    if (w_inf) begin
                        r_rx <= {{(LEN-1){1'b0}}, 1'b1};
                        r_ry <= {{(LEN-1){1'b0}}, 1'b1};
                        r_rz <= '0;
                    end else if (r_cnt == '0) begin
                        r_acc <= '0;
                        r_ma  <= w_opA;
                        r_mb  <= w_opB;
                        r_cnt <= CW'(1);
                    end else begin
                        r_acc <= w_mulNext;
                        r_ma  <= {r_ma[LEN-2:0], 1'b0};
                        if (w_mulDone) begin
                            r_reg[w_dst] <= w_mulNext;
                            r_cnt        <= '0;
                            r_step       <= r_step + 5'd1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ADDSUB: if (enable) begin
                    r_reg[w_dst] <= w_asRes;
                    r_step       <= r_step + 5'd1;
                    if (w_lastStep) begin
                        r_rx <= r_reg[0];
                        r_ry <= w_asRes;
                        r_rz <= r_reg[2];
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx   = r_rx;
    assign ry   = r_ry;
    assign rz   = r_rz;
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_point_double.sv
// Self-checking bench for point_double: an 8-bit instance for directed/random small-prime cases and a 256-bit instance on P-256.
// Expectations come from a modular-arithmetic model of the doubling formula.
module tb_point_double;

    typedef logic [255:0] big_t;

    localparam big_t P256 = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam big_t GX   = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
    localparam big_t GY   = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] p8, x8, y8, z8, rx8, ry8, rz8;
    logic       en8, done8;
    big_t       p256, x256, y256, z256, rx256, ry256, rz256;
    logic       en256, done256;

    int testsRun    = 0;
    int testsFailed = 0;

    point_double #(.LEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .p(p8), .enable(en8),
        .x(x8), .y(y8), .z(z8), .rx(rx8), .ry(ry8), .rz(rz8), .done(done8)
    );

    point_double #(.LEN(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .p(p256), .enable(en256),
        .x(x256), .y(y256), .z(z256), .rx(rx256), .ry(ry256), .rz(rz256), .done(done256)
    );

    function automatic big_t mAdd(input big_t a, input big_t b, input big_t m);
        logic [256:0] t;
        t = ({1'b0, a} + {1'b0, b}) % {1'b0, m};
        return t[255:0];
    endfunction

    function automatic big_t mSub(input big_t a, input big_t b, input big_t m);
        logic [256:0] t;
        t = ({1'b0, a} + {1'b0, m} - {1'b0, b}) % {1'b0, m};
        return t[255:0];
    endfunction

    function automatic big_t mMul(input big_t a, input big_t b, input big_t m);
        logic [511:0] t;
        t = ({256'd0, a} * {256'd0, b}) % {256'd0, m};
        return t[255:0];
    endfunction

    task automatic modelDouble(input big_t px, input big_t py, input big_t pz, input big_t m,
                               output big_t ex, output big_t ey, output big_t ez);
        big_t delta, gamma, beta, alpha, yz;
        delta = mMul(pz, pz, m);
        gamma = mMul(py, py, m);
        beta  = mMul(px, gamma, m);
        alpha = mMul(big_t'(3), mMul(mSub(px, delta, m), mAdd(px, delta, m), m), m);
        ex    = mSub(mMul(alpha, alpha, m), mMul(big_t'(8), beta, m), m);
        yz    = mAdd(py, pz, m);
        ez    = mSub(mSub(mMul(yz, yz, m), gamma, m), delta, m);
        ey    = mSub(mMul(alpha, mSub(mMul(big_t'(4), beta, m), ex, m), m),
                     mMul(big_t'(8), mMul(gamma, gamma, m), m), m);
    endtask

    function automatic big_t randBig();
        big_t r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Drops enable for one cycle, applies a request and returns the edge index at which done was first seen (-1 on timeout).
    task automatic runOp8(input logic [7:0] pp, input logic [7:0] xx, input logic [7:0] yy,
                          input logic [7:0] zz, input bit scramble, output int cycles);
        en8 = 1'b0;
        @(posedge clk); @(negedge clk);
        p8 = pp; x8 = xx; y8 = yy; z8 = zz; en8 = 1'b1;
        cycles = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); @(negedge clk);
            if (scramble && n == 2) begin
                p8 = 8'($urandom); x8 = 8'($urandom); y8 = 8'($urandom); z8 = 8'($urandom);
            end
            if (done8) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic runOp256(input big_t xx, input big_t yy, input big_t zz, output int cycles);
        en256 = 1'b0;
        @(posedge clk); @(negedge clk);
        p256 = P256; x256 = xx; y256 = yy; z256 = zz; en256 = 1'b1;
        cycles = -1;
        for (int n = 0; n < 2300; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 2) begin
                x256 = randBig(); y256 = randBig(); z256 = randBig(); p256 = randBig();
            end
            if (done256) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en8 = 1'b1; en256 = 1'b1;
        p8 = 8'd23; x8 = 8'd5; y8 = 8'd6; z8 = 8'd7;
        p256 = P256; x256 = GX; y256 = GY; z256 = big_t'(1);
        repeat (3) @(negedge clk);
        testsRun++;
        if (done8 !== 1'b0 || rx8 !== 8'd0 || ry8 !== 8'd0 || rz8 !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset8: got done=%b r=(%0d,%0d,%0d) expected done=0 r=(0,0,0)", done8, rx8, ry8, rz8);
        end
        testsRun++;
        if (done256 !== 1'b0 || rx256 !== '0 || ry256 !== '0 || rz256 !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset256: got done=%b rx=%h expected done=0 and zero outputs", done256, rx256);
        end
        en8 = 1'b0; en256 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        int cyc;
        runOp8(8'd23, 8'd1, 8'd1, 8'd1, 1'b0, cyc);
        testsRun++;
        if (cyc !== 89) begin
            testsFailed++;
            $display("[TB] FAIL latency111: got %0d expected 89", cyc);
        end
        testsRun++;
        if (rx8 !== 8'd15 || ry8 !== 8'd15 || rz8 !== 8'd2) begin
            testsFailed++;
            $display("[TB] FAIL result111: got (%0d,%0d,%0d) expected (15,15,2)", rx8, ry8, rz8);
        end
    endtask

    task automatic test_hold_high();
        int cyc;
        runOp8(8'd23, 8'd2, 8'd3, 8'd1, 1'b0, cyc);
        testsRun++;
        if (cyc !== 89 || rx8 !== 8'd6 || ry8 !== 8'd15 || rz8 !== 8'd6) begin
            testsFailed++;
            $display("[TB] FAIL result231: got cyc=%0d (%0d,%0d,%0d) expected cyc=89 (6,15,6)", cyc, rx8, ry8, rz8);
        end
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 10 || i == 149) begin
                testsRun++;
                if (done8 !== 1'b1 || rx8 !== 8'd6 || ry8 !== 8'd15 || rz8 !== 8'd6) begin
                    testsFailed++;
                    $display("[TB] FAIL holdHigh@%0d: got done=%b (%0d,%0d,%0d) expected done=1 (6,15,6)", i, done8, rx8, ry8, rz8);
                end
            end
        end
        en8 = 1'b0;
        @(posedge clk); @(negedge clk);
        testsRun++;
        if (done8 !== 1'b0 || rx8 !== 8'd6) begin
            testsFailed++;
            $display("[TB] FAIL doneFall: got done=%b rx=%0d expected done=0 rx=6", done8, rx8);
        end
    endtask

    task automatic test_abort();
        int cyc;
        runOp8(8'd23, 8'd1, 8'd1, 8'd1, 1'b0, cyc);
        en8 = 1'b0;
        @(posedge clk); @(negedge clk);
        p8 = 8'd23; x8 = 8'd2; y8 = 8'd3; z8 = 8'd1; en8 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); @(negedge clk);
        end
        en8 = 1'b0;
        @(posedge clk); @(negedge clk);
        testsRun++;
        if (done8 !== 1'b0 || rx8 !== 8'd15 || ry8 !== 8'd15 || rz8 !== 8'd2) begin
            testsFailed++;
            $display("[TB] FAIL abort: got done=%b (%0d,%0d,%0d) expected done=0 (15,15,2)", done8, rx8, ry8, rz8);
        end
        runOp8(8'd23, 8'd2, 8'd3, 8'd1, 1'b0, cyc);
        testsRun++;
        if (cyc !== 89 || rx8 !== 8'd6 || ry8 !== 8'd15 || rz8 !== 8'd6) begin
            testsFailed++;
            $display("[TB] FAIL afterAbort: got cyc=%0d (%0d,%0d,%0d) expected cyc=89 (6,15,6)", cyc, rx8, ry8, rz8);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        en8 = 1'b0;
        @(posedge clk); @(negedge clk);
        p8 = 8'd23; x8 = 8'd1; y8 = 8'd1; z8 = 8'd1; en8 = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if (done8 !== 1'b0 || rx8 !== 8'd0 || ry8 !== 8'd0 || rz8 !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL asyncReset: got done=%b (%0d,%0d,%0d) expected done=0 (0,0,0)", done8, rx8, ry8, rz8);
        end
        @(negedge clk);
        en8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runOp8(8'd23, 8'd1, 8'd1, 8'd1, 1'b0, cyc);
        testsRun++;
        if (cyc !== 89 || rx8 !== 8'd15 || ry8 !== 8'd15 || rz8 !== 8'd2) begin
            testsFailed++;
            $display("[TB] FAIL afterReset: got cyc=%0d (%0d,%0d,%0d) expected cyc=89 (15,15,2)", cyc, rx8, ry8, rz8);
        end
    endtask

    task automatic test_degenerate();
        int   cyc;
        big_t ex, ey, ez;
        runOp8(8'd23, 8'd5, 8'd7, 8'd0, 1'b0, cyc);
`ifdef POINT_DOUBLE_INF_CHECK_EN
        ex = big_t'(1); ey = big_t'(1); ez = '0;
        testsRun++;
        if (cyc !== 2) begin
            testsFailed++;
            $display("[TB] FAIL infLatency: got %0d expected 2", cyc);
        end
`else
        modelDouble(big_t'(5), big_t'(7), '0, big_t'(23), ex, ey, ez);
        testsRun++;
        if (cyc !== 89) begin
            testsFailed++;
            $display("[TB] FAIL degenLatency: got %0d expected 89", cyc);
        end
`endif
        testsRun++;
        if (rx8 !== ex[7:0] || ry8 !== ey[7:0] || rz8 !== ez[7:0]) begin
            testsFailed++;
            $display("[TB] FAIL degenerate: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", rx8, ry8, rz8, ex, ey, ez);
        end
    endtask

    task automatic test_random_small();
        int         cyc;
        int         primes [3] = '{23, 97, 251};
        int         pr;
        logic [7:0] xx, yy, zz;
        big_t       ex, ey, ez;
        for (int i = 0; i < 6; i++) begin
            pr = primes[i % 3];
            xx = 8'($urandom_range(pr - 1, 0));
            yy = 8'($urandom_range(pr - 1, 1));
            zz = 8'($urandom_range(pr - 1, 1));
            modelDouble(big_t'(xx), big_t'(yy), big_t'(zz), big_t'(pr), ex, ey, ez);
            runOp8(8'(pr), xx, yy, zz, 1'b1, cyc);
            testsRun++;
            if (cyc !== 89 || rx8 !== ex[7:0] || ry8 !== ey[7:0] || rz8 !== ez[7:0]) begin
                testsFailed++;
                $display("[TB] FAIL random8 p=%0d (%0d,%0d,%0d): got cyc=%0d (%0d,%0d,%0d) expected cyc=89 (%0d,%0d,%0d)",
                         pr, xx, yy, zz, cyc, rx8, ry8, rz8, ex, ey, ez);
            end
        end
    endtask

    task automatic test_p256();
        int   cyc;
        big_t zz, z2, xx, yy, ex, ey, ez;
        for (int i = 0; i < 3; i++) begin
            zz = (i == 0) ? big_t'(1) : randBig() % P256;
            if (zz == '0) zz = big_t'(1);
            z2 = mMul(zz, zz, P256);
            xx = mMul(GX, z2, P256);
            yy = mMul(GY, mMul(z2, zz, P256), P256);
            modelDouble(xx, yy, zz, P256, ex, ey, ez);
            runOp256(xx, yy, zz, cyc);
            testsRun++;
            if (cyc !== 2073) begin
                testsFailed++;
                $display("[TB] FAIL p256Latency#%0d: got %0d expected 2073", i, cyc);
            end
            testsRun++;
            if (rx256 !== ex || ry256 !== ey || rz256 !== ez) begin
                testsFailed++;
                $display("[TB] FAIL p256Result#%0d: got rx=%h ry=%h rz=%h expected rx=%h ry=%h rz=%h",
                         i, rx256, ry256, rz256, ex, ey, ez);
            end
        end
        en256 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_hold_high();
        test_abort();
        test_async_reset();
        test_degenerate();
        test_random_small();
        test_p256();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/point_double.md
POINT_DOUBLE -- requirements
Module: point_double

Interface
REQ-001 Parameter LEN, default 256: coordinate and modulus width in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 p  input  LEN  odd prime modulus, p > 3, held stable while busy.
REQ-005 enable  input  1  level request; high starts an operation, low returns block to idle.
REQ-006 x, y, z  input  LEN each  Jacobian input point, each < p, captured at start.
REQ-007 rx, ry, rz  output  LEN each  Jacobian result 2P in standard (non-Montgomery) residues, each < p; feeds the affine-conversion stage directly.
REQ-008 done  output  1  result valid; held until enable falls.

Function
REQ-009 Curve coefficient a = -3 is fixed; formula: delta=Z^2, gamma=Y^2, beta=X*gamma, alpha=3(X-delta)(X+delta), X3=alpha^2-8beta, Z3=(Y+Z)^2-gamma-delta, Y3=alpha(4beta-X3)-8gamma^2, all mod p.
REQ-010 FSM states IDLE, LOAD, MUL, ADDSUB, DONE; micro-sequence of exactly 8 multiplies and 16 add/sub ops in the order of REQ-009.
REQ-011 IDLE -> LOAD when enable=1; LOAD captures x, y, z into working registers (1 cycle).
REQ-012 Multiply: internal bit-serial interleaved modular multiplier, MSB first, acc=2acc mod p then acc+=b mod p if bit set; 1 setup cycle + LEN iteration cycles = LEN+1 cycles per multiply.
REQ-013 Add/sub: 1 cycle each; sums computed in LEN+1 bits with one conditional subtraction of p; differences add p on borrow; result always < p.
REQ-014 Latency: done rises exactly 8(LEN+1)+17 cycles after the first rising edge sampling enable=1 in IDLE (2073 for LEN=256).
REQ-015 DONE: rx/ry/rz stable, done=1; remains until enable=0, then IDLE with done=0 next cycle; outputs keep last values.
REQ-016 enable falling mid-operation aborts: next cycle IDLE, done=0, rx/ry/rz unchanged from previous result.
REQ-017 enable held high after done does not restart; a new operation requires enable low for at least one cycle.
REQ-018 Inputs x, y, z, p changes after LOAD have no effect on the running operation.

Reset
REQ-019 rst_n=0 forces IDLE, done=0, rx=ry=rz=0, all working registers and counters 0, immediately and independent of clk.
REQ-020 Reset mid-operation discards work; after release block waits for enable=1 in IDLE.

Configuration
REQ-021 Macro POINT_DOUBLE_INF_CHECK_EN: when defined, LOAD detecting z==0 or y==0 jumps straight to DONE with rx=1, ry=1, rz=0 (point at infinity), done rising 2 cycles after enable sampled.
REQ-022 Without POINT_DOUBLE_INF_CHECK_EN no check is made; such inputs run the full sequence with full latency and formula result.

Verification
REQ-023 LEN=8, p=23, (x,y,z)=(1,1,1), enable high -> done after 89 cycles, (rx,ry,rz)=(15,15,2).
REQ-024 LEN=8, p=23, (2,3,1) -> (6,15,6) after 89 cycles; enable held high afterwards -> no restart, done stays 1.
REQ-025 LEN=8, p=23, (2,3,1), enable dropped at cycle 40 -> done=0, outputs unchanged, IDLE; re-raise -> (6,15,6) after 89 further cycles.
REQ-026 rst_n pulsed low mid-operation -> outputs 0, done 0 asynchronously; next run of (1,1,1) returns (15,15,2).
REQ-027 Macro defined, (5,7,0) -> (1,1,0) with done 2 cycles after enable; macro undefined -> done after 89 cycles, rz=0.
REQ-028 LEN=256, p=P-256 prime, random points on curve -> results match software Jacobian doubling; done exactly 2073 cycles after start.
